// File: rtl/ray_vector_pkg.sv
// Shared types and constants for packed 57-bit ray-tracing vectors.
// Used by the add, subtract, divide and multiply vector blocks.
package ray_vector_pkg;

  localparam int VEC_W  = 57;
  localparam int COMP_W = 19;

  localparam int X_LSB = 38;
  localparam int Y_LSB = 19;
  localparam int Z_LSB = 0;

  // Shift-add accumulator width: full product of two 19-bit magnitudes
  localparam int ACC_W = 2 * COMP_W;

  // Iteration counter: one multiplier bit per cycle, 0..COMP_W-1
  localparam int CNT_W     = 5;
  localparam int LAST_ITER = COMP_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } svm_state_e;

endpackage

// File: rtl/signed_mul_lane.sv
// One signed fixed-point multiply lane: magnitude/sign capture,
// radix-2 shift-add accumulate, then shift, sign and range check.
// Optional macro SVM_SATURATE_EN clamps out-of-range results.
module signed_mul_lane
  import ray_vector_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_fin,
  input  logic [COMP_W-1:0] i_a,
  input  logic [COMP_W-1:0] i_b,
  output logic [COMP_W-1:0] o_res,
  output logic              o_ovf
);

  localparam logic [ACC_W-1:0] LIM_POS =
    ACC_W'((64'd1 << (COMP_W - 1)) - 64'd1);
  localparam logic [ACC_W-1:0] LIM_NEG =
    ACC_W'(64'd1 << (COMP_W - 1));
  localparam logic [COMP_W-1:0] SAT_POS =
    COMP_W'((64'd1 << (COMP_W - 1)) - 64'd1);
  localparam logic [COMP_W-1:0] SAT_NEG =
    COMP_W'(64'd1 << (COMP_W - 1));

  logic [ACC_W-1:0]  r_mcand;
  logic [COMP_W-1:0] r_mplier;
  logic              r_sign;
  logic [ACC_W-1:0]  r_acc;
  logic [COMP_W-1:0] r_res;
  logic              r_ovf;

  logic [COMP_W-1:0] w_mag_a;
  logic [COMP_W-1:0] w_mag_b;
  logic              w_sign;
  logic [ACC_W-1:0]  w_q;
  logic [ACC_W-1:0]  w_lim;
  logic              w_ovf;
  logic [COMP_W-1:0] w_low;
  logic [COMP_W-1:0] w_wrap;
  logic [COMP_W-1:0] w_res;

  // Operand magnitudes; -2^18 maps to 2^18 as an unsigned value
  assign w_mag_a = i_a[COMP_W-1] ? (~i_a + 1'b1) : i_a;
  assign w_mag_b = i_b[COMP_W-1] ? (~i_b + 1'b1) : i_b;

  // A zero operand forces a positive result sign
  assign w_sign = (i_a[COMP_W-1] ^ i_b[COMP_W-1])
                & (|i_a) & (|i_b);

  // Capture operands, then one multiplier bit per step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sign   <= 1'b0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{(ACC_W-COMP_W){1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_sign   <= w_sign;
      r_acc    <= '0;
    end else if (i_step) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  // Scale, range-check and re-sign the accumulated magnitude
  always_comb begin
    w_q    = r_acc >> FRAC_BITS;
    w_lim  = r_sign ? LIM_NEG : LIM_POS;
    w_ovf  = (w_q > w_lim);
    w_low  = w_q[COMP_W-1:0];
    w_wrap = r_sign ? (~w_low + 1'b1) : w_low;
`ifdef SVM_SATURATE_EN
    w_res  = w_ovf ? (r_sign ? SAT_NEG : SAT_POS) : w_wrap;
`else
    w_res  = w_wrap;
`endif
  end

  // Result register, written once on DONE entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res <= '0;
      r_ovf <= 1'b0;
    end else if (i_fin) begin
      r_res <= w_res;
      r_ovf <= w_ovf;
    end
  end

  assign o_res = r_res;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/signed_vector_multiplication_seq.sv
// Multi-cycle component-wise signed Q-format vector multiplier.
// Optional macro SVM_SATURATE_EN: clamp overflowing lanes.
module signed_vector_multiplication_seq
  import ray_vector_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vector_1,
  input  logic [VEC_W-1:0] in_vector_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vector,
  output logic [2:0]       out_ovf
);

  svm_state_e r_state;
  svm_state_e w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;

  logic w_load;
  logic w_step;
  logic w_fin;
  logic w_done_hs;

  logic [COMP_W-1:0] w_rx;
  logic [COMP_W-1:0] w_ry;
  logic [COMP_W-1:0] w_rz;
  logic              w_ox;
  logic              w_oy;
  logic              w_oz;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and lane control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fin       = 1'b0;
    w_done_hs   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(LAST_ITER)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!r_out_valid) begin
          w_fin = 1'b1;
        end else if (out_ready) begin
          w_done_hs   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Iteration counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Output valid: set on DONE entry, cleared on handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (w_fin) begin
      r_out_valid <= 1'b1;
    end else if (w_done_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  signed_mul_lane #(.FRAC_BITS(FRAC_BITS)) u_lane_x (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_fin  (w_fin),
    .i_a    (in_vector_1[X_LSB +: COMP_W]),
    .i_b    (in_vector_2[X_LSB +: COMP_W]),
    .o_res  (w_rx),
    .o_ovf  (w_ox)
  );

  signed_mul_lane #(.FRAC_BITS(FRAC_BITS)) u_lane_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_fin  (w_fin),
    .i_a    (in_vector_1[Y_LSB +: COMP_W]),
    .i_b    (in_vector_2[Y_LSB +: COMP_W]),
    .o_res  (w_ry),
    .o_ovf  (w_oy)
  );

  signed_mul_lane #(.FRAC_BITS(FRAC_BITS)) u_lane_z (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_fin  (w_fin),
    .i_a    (in_vector_1[Z_LSB +: COMP_W]),
    .i_b    (in_vector_2[Z_LSB +: COMP_W]),
    .o_res  (w_rz),
    .o_ovf  (w_oz)
  );

  assign in_ready   = (r_state == ST_IDLE) & rst_n;
  assign out_valid  = r_out_valid;
  assign out_vector = {w_rx, w_ry, w_rz};
  assign out_ovf    = {w_ox, w_oy, w_oz};

endmodule

// File: tb/tb_signed_vector_multiplication_seq.sv
// Bench for signed_vector_multiplication_seq: table vectors,
// handshake corner sequences and random ops against a model.
module tb_signed_vector_multiplication_seq;

  localparam int FRAC = 8;
  localparam int LAT  = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [56:0] in_vector_1;
  logic [56:0] in_vector_2;
  logic        out_valid;
  logic        out_ready;
  logic [56:0] out_vector;
  logic [2:0]  out_ovf;

  int n_vec = 0;
  int n_mis = 0;

  signed_vector_multiplication_seq #(.FRAC_BITS(FRAC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vector_1 (in_vector_1),
    .in_vector_2 (in_vector_2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vector  (out_vector),
    .out_ovf     (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [56:0] a;
    logic [56:0] b;
    logic [56:0] e;
    logic [2:0]  o;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [56:0] pk(input int x, input int y,
                                     input int z);
    return {x[18:0], y[18:0], z[18:0]};
  endfunction

  // Reference: exact product, truncate magnitude, then range rule
  function automatic logic [59:0] model(input logic [56:0] a,
                                        input logic [56:0] b);
    logic [56:0] v;
    logic [2:0]  o;
    v = '0;
    o = '0;
    for (int i = 0; i < 3; i++) begin
      longint sa, sb, p, m, r;
      logic   ov;
      sa = longint'($signed(a[i*19 +: 19]));
      sb = longint'($signed(b[i*19 +: 19]));
      p  = sa * sb;
      m  = (p < 0 ? -p : p) >> FRAC;
      r  = (p < 0) ? -m : m;
      ov = (r > 262143) || (r < -262144);
`ifdef SVM_SATURATE_EN
      if (ov) r = (p < 0) ? -262144 : 262143;
`endif
      v[i*19 +: 19] = r[18:0];
      o[i] = ov;
    end
    return {o, v};
  endfunction

  function automatic logic [56:0] rnd57();
    return 57'({$urandom(), $urandom()});
  endfunction

  // One full transaction: accept, wait for result, optional
  // backpressure, optional operand pokes during RUN, handshake.
  task automatic run_op(input logic [56:0] a, input logic [56:0] b,
                        input int bp, input bit poke,
                        output logic [56:0] r, output logic [2:0] o,
                        output int lat);
    int  n;
    bit  bad;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", 64'(in_ready), 64'd1);
    in_vector_1 = a;
    in_vector_2 = b;
    in_valid    = 1'b1;
    out_ready   = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad = 1'b1;
      if (poke) begin
        in_valid = (lat == 5 || lat == 6 || lat == 12);
        if (in_valid) in_vector_1 = rnd57();
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("busy_in_ready", 64'(bad), 64'd0);
    r = out_vector;
    o = out_ovf;
    bad = 1'b0;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      if (out_vector !== r || out_ovf !== o || !out_valid
          || in_ready) bad = 1'b1;
    end
    if (bp > 0) chk("bp_hold", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_idle", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    logic [56:0] r;
    logic [2:0]  o;
    logic [59:0] m;
    logic [56:0] ra, rb;
    int          lat;

    tbl[0] = '{pk(512, -384, 128), pk(768, 768, 768),
               pk(1536, -1152, 384), 3'b000};
    tbl[1] = '{pk(-1, -256, -262144), pk(1, -256, 256),
               pk(0, 256, -262144), 3'b000};
`ifdef SVM_SATURATE_EN
    tbl[2] = '{pk(262143, 262143, 262143),
               pk(262143, 262143, 262143),
               pk(262143, 262143, 262143), 3'b111};
    tbl[3] = '{pk(-262144, 0, 0), pk(-256, 0, 0),
               pk(262143, 0, 0), 3'b100};
`else
    tbl[2] = '{pk(262143, 262143, 262143),
               pk(262143, 262143, 262143),
               pk(522240, 522240, 522240), 3'b111};
    tbl[3] = '{pk(-262144, 0, 0), pk(-256, 0, 0),
               pk(262144, 0, 0), 3'b100};
`endif
    tbl[4] = '{pk(0, -5, 300), pk(-7, 0, -300),
               pk(0, 0, -351), 3'b000};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_vector_1 = '0;
    in_vector_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {out_valid, out_ovf, in_ready, out_vector},
        64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_ready", 64'(in_ready), 64'd1);

    // Table vectors; row 0 also exercises 5 cycles of backpressure
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].a, tbl[i].b, (i == 0) ? 5 : 0, 1'b0, r, o, lat);
      chk($sformatf("tbl%0d_vec", i), 64'(r), 64'(tbl[i].e));
      chk($sformatf("tbl%0d_ovf", i), 64'(o), 64'(tbl[i].o));
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(LAT));
    end

    // Ignored input: pokes during RUN must not disturb the result
    ra = pk(1000, -2000, 3000);
    rb = pk(-700, 600, 512);
    m  = model(ra, rb);
    run_op(ra, rb, 0, 1'b1, r, o, lat);
    chk("poke_vec", 64'(r), 64'(m[56:0]));
    chk("poke_ovf", 64'(o), 64'(m[59:57]));
    chk("poke_lat", 64'(lat), 64'(LAT));
    repeat (3) @(posedge clk);
    #1;
    chk("poke_no_2nd", {62'd0, out_valid, in_ready}, 64'd1);

    // Reset at iteration 10, previous result still on the outputs
    in_vector_1 = pk(300, 400, 500);
    in_vector_2 = pk(600, 700, 800);
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out", {out_valid, out_ovf, in_ready, out_vector},
        64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", {62'd0, out_valid, in_ready}, 64'd1);
    ra = pk(-12345, 54321, -1);
    rb = pk(4321, -999, -1);
    m  = model(ra, rb);
    run_op(ra, rb, 0, 1'b0, r, o, lat);
    chk("post_rst_vec", 64'(r), 64'(m[56:0]));
    chk("post_rst_ovf", 64'(o), 64'(m[59:57]));

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      ra = rnd57();
      rb = rnd57();
      if (i % 3 == 0) rb = pk($urandom_range(0, 2047) - 1024,
                              $urandom_range(0, 2047) - 1024,
                              $urandom_range(0, 2047) - 1024);
      m = model(ra, rb);
      run_op(ra, rb, $urandom_range(0, 2), 1'b0, r, o, lat);
      chk($sformatf("rnd%0d_vec", i), 64'(r), 64'(m[56:0]));
      chk($sformatf("rnd%0d_ovf", i), 64'(o), 64'(m[59:57]));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(LAT));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
